// File: rtl/mac_lookup_arbiter_pkg.sv
// Shared MAC table definitions: field widths, the lookup request record and
// the requester-index to physical-port mapping used by table clients.
package mac_table_pkg;

   localparam int unsigned PORT_W = 5;
   localparam int unsigned VLAN_W = 12;
   localparam int unsigned MAC_W  = 48;

   typedef struct packed {
      logic [VLAN_W-1:0] vlan;
      logic [MAC_W-1:0]  src_mac;
      logic [MAC_W-1:0]  dst_mac;
   } lookup_req_t;

   // Physical switch port of a requester; wraps into the 5-bit port field
   function automatic logic [PORT_W-1:0] phys_port(input int unsigned base,
                                                   input int unsigned idx);
      int unsigned sum;
      sum = base + idx;
      return sum[PORT_W-1:0];
   endfunction

endpackage

// File: rtl/mac_lookup_arbiter_if.sv
// Bundle of the requester handshake, table lookup port and response bus of
// the MAC lookup arbiter. slave = arbiter side, master = environment side.
interface mac_lookup_arbiter_if #(
   parameter int unsigned NUM_PORTS = 4
);
   import mac_table_pkg::*;

   // requester side
   logic [NUM_PORTS-1:0]             req_valid;
   logic [NUM_PORTS-1:0]             req_ready;
   logic [NUM_PORTS-1:0][VLAN_W-1:0] req_vlan;
   logic [NUM_PORTS-1:0][MAC_W-1:0]  req_src_mac;
   logic [NUM_PORTS-1:0][MAC_W-1:0]  req_dst_mac;

   // table lookup port
   logic              lookup_en;
   logic [VLAN_W-1:0] lookup_src_vlan;
   logic [MAC_W-1:0]  lookup_src_mac;
   logic [PORT_W-1:0] lookup_src_port;
   logic [MAC_W-1:0]  lookup_dst_mac;
   logic              lookup_hit;
   logic [PORT_W-1:0] lookup_dst_port;

   // responses back to requesters
   logic [NUM_PORTS-1:0] resp_valid;
   logic                 resp_hit;
   logic [PORT_W-1:0]    resp_dst_port;

   modport slave (
      input  req_valid, req_vlan, req_src_mac, req_dst_mac,
      input  lookup_hit, lookup_dst_port,
      output req_ready,
      output lookup_en, lookup_src_vlan, lookup_src_mac, lookup_src_port, lookup_dst_mac,
      output resp_valid, resp_hit, resp_dst_port
   );

   modport master (
      output req_valid, req_vlan, req_src_mac, req_dst_mac,
      output lookup_hit, lookup_dst_port,
      input  req_ready,
      input  lookup_en, lookup_src_vlan, lookup_src_mac, lookup_src_port, lookup_dst_mac,
      input  resp_valid, resp_hit, resp_dst_port
   );

endinterface

// File: rtl/mac_lookup_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer; the pointer moves just past the winner and holds otherwise.
module rr_arbiter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] gnt_o
);

   localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             found;
   int unsigned      idx;

   // Scan from the pointer with wrap-around and pick the first requester
   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int unsigned off = 0; off < WIDTH; off++) begin
         idx = (32'(ptr_q) + off) % WIDTH;
         if (en_i && !found && req_i[idx[PTR_W-1:0]]) begin
            found                  = 1'b1;
            gnt_o[idx[PTR_W-1:0]] = 1'b1;
            ptr_d                  = (idx + 1 == WIDTH) ? '0 : PTR_W'(idx + 1);
         end
      end
   end

   // Pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mac_lookup_arbiter.sv
// Shares the MAC table lookup port between NUM_PORTS ingress requesters:
// round-robin grant, registered lookup launch, fixed-latency tag pipeline
// routing each result back to the requester that issued it.
module mac_lookup_arbiter
   import mac_table_pkg::*;
#(
   parameter int unsigned NUM_PORTS      = 4,
   parameter int unsigned PORT_BASE      = 0,
   parameter int unsigned LOOKUP_LATENCY = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pause,
   mac_lookup_arbiter_if.slave  bus
);

   localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NUM_PORTS-1:0] grant;
   logic                 arb_en;
   logic                 grant_any;
   logic [IDX_W-1:0]     grant_idx;

   lookup_req_t          lookup_req_d, lookup_req_q;
   logic [PORT_W-1:0]    lookup_port_d, lookup_port_q;
   logic                 lookup_en_q;
   logic [IDX_W-1:0]     lookup_idx_q;

   logic [LOOKUP_LATENCY-1:0]            tag_vld_q;
   logic [LOOKUP_LATENCY-1:0][IDX_W-1:0] tag_idx_q;
   logic                                 tag_out_vld;
   logic [IDX_W-1:0]                     tag_out_idx;

   logic [NUM_PORTS-1:0] resp_valid_d, resp_valid_q;
   logic                 resp_hit_q;
   logic [PORT_W-1:0]    resp_dst_port_q;

   // Grants are suppressed while paused and while reset is asserted so that
   // req_ready reads 0 during reset
   assign arb_en = ~pause & ~rst;

   rr_arbiter #(
      .WIDTH (NUM_PORTS)
   ) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (bus.req_valid),
      .en_i  (arb_en),
      .gnt_o (grant)
   );

   assign bus.req_ready = grant;

   // Encode the one-hot grant into a requester index
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (grant[i]) begin
            grant_any = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
   end

   // Select the granted requester's fields for the lookup port
   always_comb begin
      lookup_req_d.vlan    = bus.req_vlan[grant_idx];
      lookup_req_d.src_mac = bus.req_src_mac[grant_idx];
      lookup_req_d.dst_mac = bus.req_dst_mac[grant_idx];
      lookup_port_d        = phys_port(PORT_BASE, 32'(grant_idx));
   end

   // Lookup launch registers; data holds its last value when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lookup_en_q   <= 1'b0;
         lookup_req_q  <= '0;
         lookup_port_q <= '0;
         lookup_idx_q  <= '0;
      end else begin
         lookup_en_q <= grant_any;
         if (grant_any) begin
            lookup_req_q  <= lookup_req_d;
            lookup_port_q <= lookup_port_d;
            lookup_idx_q  <= grant_idx;
         end
      end
   end

   assign bus.lookup_en       = lookup_en_q;
   assign bus.lookup_src_vlan = lookup_req_q.vlan;
   assign bus.lookup_src_mac  = lookup_req_q.src_mac;
   assign bus.lookup_dst_mac  = lookup_req_q.dst_mac;
   assign bus.lookup_src_port = lookup_port_q;

   // Tag pipeline fed from the launch register: the tag leaves the last stage
   // exactly in the cycle the table presents that lookup's result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld_q <= '0;
         tag_idx_q <= '0;
      end else begin
         tag_vld_q[0] <= lookup_en_q;
         tag_idx_q[0] <= lookup_idx_q;
         for (int unsigned s = 1; s < LOOKUP_LATENCY; s++) begin
            tag_vld_q[s] <= tag_vld_q[s-1];
            tag_idx_q[s] <= tag_idx_q[s-1];
         end
      end
   end

   assign tag_out_vld = tag_vld_q[LOOKUP_LATENCY-1];
   assign tag_out_idx = tag_idx_q[LOOKUP_LATENCY-1];

   // One-hot response target for the exiting tag
   always_comb begin
      resp_valid_d = '0;
      if (tag_out_vld) resp_valid_d[tag_out_idx] = 1'b1;
   end

   // Response registers: capture the table result alongside the exiting tag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resp_valid_q    <= '0;
         resp_hit_q      <= 1'b0;
         resp_dst_port_q <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         if (tag_out_vld) begin
            resp_hit_q      <= bus.lookup_hit;
            resp_dst_port_q <= bus.lookup_dst_port;
         end
      end
   end

   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_hit      = resp_hit_q;
   assign bus.resp_dst_port = resp_dst_port_q;

endmodule

// File: tb/tb_mac_lookup_arbiter.sv
// Bench for mac_lookup_arbiter: a small table model answers lookups, and
// expected lookups/responses are queued at grant time and checked on output.
module tb_mac_lookup_arbiter;
   import mac_table_pkg::*;

   localparam int unsigned NP  = 4;
   localparam int unsigned PB  = 8;
   localparam int unsigned LAT = 3;

   logic clk = 1'b0;
   logic rst;
   logic pause;

   always #5 clk = ~clk;

   mac_lookup_arbiter_if #(.NUM_PORTS(NP)) bus ();

   mac_lookup_arbiter #(
      .NUM_PORTS      (NP),
      .PORT_BASE      (PB),
      .LOOKUP_LATENCY (LAT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .pause (pause),
      .bus   (bus)
   );

   typedef struct {
      int unsigned cyc;
      logic [11:0] vlan;
      logic [47:0] sm;
      logic [47:0] dm;
      logic [4:0]  port;
   } lk_t;

   typedef struct {
      int unsigned   cyc;
      logic [NP-1:0] vec;
      logic          hit;
      logic [4:0]    port;
   } rs_t;

   lk_t lkq[$];
   rs_t rsq[$];

   int          total = 0;
   int          bad   = 0;
   int unsigned cyc   = 0;
   int unsigned m_ptr = 0;
   int          gcnt[NP];
   int          last_gi = -1;
   int unsigned last_gcyc = 0;
   int unsigned resp_cnt = 0;
   int unsigned last_resp_cyc = 0;
   logic [NP-1:0] last_resp_vec = '0;
   logic          last_resp_hit = 1'b0;
   logic [4:0]    last_resp_port = '0;

   bit          rv[NP];
   bit          cont[NP];
   logic [11:0] rvl[NP];
   logic [47:0] rsm[NP];
   logic [47:0] rdm[NP];

   always @(posedge clk) cyc <= cyc + 1;

   // Table model: fixed latency, not reset, result derived from the request
   bit       tv[LAT];
   bit       th[LAT];
   bit [4:0] tp[LAT];

   always @(posedge clk) begin
      for (int j = LAT - 1; j > 0; j--) begin
         tv[j] <= tv[j-1];
         th[j] <= th[j-1];
         tp[j] <= tp[j-1];
      end
      tv[0] <= bus.lookup_en;
      th[0] <= bus.lookup_dst_mac[8] ^ bus.lookup_src_vlan[0];
      tp[0] <= bus.lookup_dst_mac[4:0] ^ 5'h06;
   end

   assign bus.lookup_hit      = tv[LAT-1] ? th[LAT-1] : 1'b0;
   assign bus.lookup_dst_port = tv[LAT-1] ? tp[LAT-1] : 5'h1f;

   function automatic logic exp_hit(input logic [11:0] v, input logic [47:0] d);
      return d[8] ^ v[0];
   endfunction

   function automatic logic [4:0] exp_port(input logic [47:0] d);
      return d[4:0] ^ 5'h06;
   endfunction

   task automatic drive();
      for (int i = 0; i < NP; i++) begin
         bus.req_valid[i]   = rv[i];
         bus.req_vlan[i]    = rvl[i];
         bus.req_src_mac[i] = rsm[i];
         bus.req_dst_mac[i] = rdm[i];
      end
   endtask

   task automatic newreq(input int i);
      rv[i]  = 1'b1;
      rvl[i] = 12'($urandom);
      rsm[i] = {16'($urandom), 32'($urandom)};
      rdm[i] = {16'($urandom), 32'($urandom)};
   endtask

   // Output monitor: lookup port and responses against the queued expectations
   always @(negedge clk) begin
      lk_t el;
      rs_t er;
      if (bus.lookup_en === 1'b1) begin
         total++;
         if (lkq.size() == 0) begin
            bad++;
            $display("FAIL lookup_unexpected cyc=%0d got lookup_en=1 want 0", cyc);
         end else begin
            el = lkq.pop_front();
            if (el.cyc != cyc || bus.lookup_src_vlan !== el.vlan || bus.lookup_src_mac !== el.sm ||
                bus.lookup_dst_mac !== el.dm || bus.lookup_src_port !== el.port) begin
               bad++;
               $display("FAIL lookup cyc=%0d got vlan=%h src=%h dst=%h port=%h want cyc=%0d vlan=%h src=%h dst=%h port=%h",
                        cyc, bus.lookup_src_vlan, bus.lookup_src_mac, bus.lookup_dst_mac, bus.lookup_src_port,
                        el.cyc, el.vlan, el.sm, el.dm, el.port);
            end
         end
      end else if (lkq.size() != 0 && lkq[0].cyc <= cyc) begin
         total++;
         bad++;
         $display("FAIL lookup_missing cyc=%0d got lookup_en=%b want 1", cyc, bus.lookup_en);
         void'(lkq.pop_front());
      end

      if (bus.resp_valid !== '0) begin
         resp_cnt++;
         last_resp_cyc  = cyc;
         last_resp_vec  = bus.resp_valid;
         last_resp_hit  = bus.resp_hit;
         last_resp_port = bus.resp_dst_port;
         total++;
         if (rsq.size() == 0) begin
            bad++;
            $display("FAIL resp_unexpected cyc=%0d got resp_valid=%b want 0", cyc, bus.resp_valid);
         end else begin
            er = rsq.pop_front();
            if (er.cyc != cyc || bus.resp_valid !== er.vec || bus.resp_hit !== er.hit ||
                bus.resp_dst_port !== er.port) begin
               bad++;
               $display("FAIL resp cyc=%0d got valid=%b hit=%b port=%h want cyc=%0d valid=%b hit=%b port=%h",
                        cyc, bus.resp_valid, bus.resp_hit, bus.resp_dst_port, er.cyc, er.vec, er.hit, er.port);
            end
         end
      end else if (rsq.size() != 0 && rsq[0].cyc <= cyc) begin
         total++;
         bad++;
         $display("FAIL resp_missing cyc=%0d got resp_valid=%b want %b", cyc, bus.resp_valid, rsq[0].vec);
         void'(rsq.pop_front());
      end
   end

   // One clock: check the grant against the round-robin model, queue
   // expectations, then update requesters after the edge
   task automatic step();
      logic [NP-1:0] eg;
      int            gi;
      int unsigned   idx;
      @(negedge clk);
      eg = '0;
      gi = -1;
      if (rst !== 1'b1 && pause !== 1'b1) begin
         for (int unsigned off = 0; off < NP; off++) begin
            idx = (m_ptr + off) % NP;
            if (gi < 0 && rv[idx]) gi = int'(idx);
         end
      end
      if (gi >= 0) eg[gi] = 1'b1;
      total++;
      if (bus.req_ready !== eg) begin
         bad++;
         $display("FAIL grant cyc=%0d got req_ready=%b want %b", cyc, bus.req_ready, eg);
      end
      if (gi >= 0) begin
         lkq.push_back('{cyc + 1, rvl[gi], rsm[gi], rdm[gi], 5'(PB + gi)});
         rsq.push_back('{cyc + 2 + LAT, eg, exp_hit(rvl[gi], rdm[gi]), exp_port(rdm[gi])});
         m_ptr = (gi + 1) % NP;
         gcnt[gi]++;
         last_gi   = gi;
         last_gcyc = cyc;
      end
      @(posedge clk);
      #1;
      if (gi >= 0) begin
         if (cont[gi]) newreq(gi);
         else          rv[gi] = 1'b0;
      end
      drive();
   endtask

   task automatic check_all_zero(input string tag);
      total++;
      if (bus.req_ready !== '0 || bus.lookup_en !== 1'b0 || bus.lookup_src_vlan !== '0 ||
          bus.lookup_src_mac !== '0 || bus.lookup_dst_mac !== '0 || bus.lookup_src_port !== '0 ||
          bus.resp_valid !== '0 || bus.resp_hit !== 1'b0 || bus.resp_dst_port !== '0) begin
         bad++;
         $display("FAIL %s got ready=%b en=%b vlan=%h src=%h dst=%h sport=%h rv=%b hit=%b dport=%h want all 0",
                  tag, bus.req_ready, bus.lookup_en, bus.lookup_src_vlan, bus.lookup_src_mac,
                  bus.lookup_dst_mac, bus.lookup_src_port, bus.resp_valid, bus.resp_hit, bus.resp_dst_port);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_values");
      rst = 1'b0;
   endtask

   task automatic test_single();
      int unsigned c0;
      rv[2]  = 1'b1;
      rvl[2] = 12'd2;
      rsm[2] = 48'h02deadbeef0c;
      rdm[2] = 48'h02deadbeef0a;
      drive();
      c0 = resp_cnt;
      step();
      total++;
      if (last_gi != 2) begin
         bad++;
         $display("FAIL single_grant got %0d want 2", last_gi);
      end
      for (int k = 0; k < 12 && resp_cnt == c0; k++) step();
      total++;
      if (resp_cnt == c0) begin
         bad++;
         $display("FAIL single_timeout got no resp want resp");
      end else if (last_resp_cyc - last_gcyc != 5 || last_resp_vec !== 4'b0100 ||
                   last_resp_hit !== 1'b1 || last_resp_port !== 5'h0c) begin
         bad++;
         $display("FAIL single_resp got lat=%0d vec=%b hit=%b port=%h want lat=5 vec=0100 hit=1 port=0c",
                  last_resp_cyc - last_gcyc, last_resp_vec, last_resp_hit, last_resp_port);
      end
   endtask

   task automatic test_order();
      newreq(1);
      drive();
      step();
      newreq(1);
      newreq(3);
      drive();
      step();
      total++;
      if (last_gi != 3) begin
         bad++;
         $display("FAIL order_first got %0d want 3", last_gi);
      end
      step();
      total++;
      if (last_gi != 1) begin
         bad++;
         $display("FAIL order_second got %0d want 1", last_gi);
      end
      for (int i = 0; i < NP; i++) newreq(i);
      drive();
      step();
      total++;
      if (last_gi != 2) begin
         bad++;
         $display("FAIL order_ptr_after got %0d want 2", last_gi);
      end
      repeat (12) step();
   endtask

   task automatic test_back_to_back();
      int g0[NP];
      for (int i = 0; i < NP; i++) begin
         cont[i] = 1'b1;
         newreq(i);
         g0[i] = gcnt[i];
      end
      drive();
      repeat (16) step();
      for (int i = 0; i < NP; i++) begin
         total++;
         if (gcnt[i] - g0[i] != 4) begin
            bad++;
            $display("FAIL fairness port%0d got %0d grants want 4", i, gcnt[i] - g0[i]);
         end
      end
   endtask

   task automatic test_pause();
      int unsigned r0;
      pause = 1'b1;
      r0 = resp_cnt;
      repeat (5) step();
      total++;
      if (resp_cnt - r0 != 5) begin
         bad++;
         $display("FAIL pause_drain got %0d resps want 5", resp_cnt - r0);
      end
      pause = 1'b0;
      step();
      total++;
      if (last_gcyc != cyc - 1) begin
         bad++;
         $display("FAIL pause_resume got last grant cyc=%0d want %0d", last_gcyc, cyc - 1);
      end
   endtask

   task automatic test_reset_midop();
      repeat (4) step();
      rst = 1'b1;
      #1;
      check_all_zero("reset_midop");
      lkq.delete();
      rsq.delete();
      m_ptr = 0;
      repeat (3) step();
      rst = 1'b0;
      step();
      total++;
      if (last_gi != 0) begin
         bad++;
         $display("FAIL reset_ptr got first grant %0d want 0", last_gi);
      end
      for (int i = 0; i < NP; i++) cont[i] = 1'b0;
      repeat (14) step();
   endtask

   initial begin
      rst   = 1'b1;
      pause = 1'b0;
      for (int i = 0; i < NP; i++) begin
         rv[i]   = 1'b0;
         cont[i] = 1'b0;
         rvl[i]  = '0;
         rsm[i]  = '0;
         rdm[i]  = '0;
         gcnt[i] = 0;
      end
      drive();
      test_reset();
      test_single();
      test_order();
      test_back_to_back();
      test_pause();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
